// File: rtl/adder_pkg.sv
// Shared defaults and stage-count derivation for the chunked pipelined adder.
package adder_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultChunk = 4;

    // A zero chunk is rejected at elaboration; return 1 so that check is reached cleanly.
    function automatic int unsigned num_stages(int unsigned width, int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Handshake bus for pipe_adder: input operand channel and output result channel.
// PIPE_ADDER_OVF_EN adds the signed-overflow flag to the result channel.
interface pipe_adder_if #(
    parameter int unsigned WIDTH = adder_pkg::DefaultWidth
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/adder_chunk.sv
// Combinational ripple-carry adder for one pipeline chunk.
module adder_chunk #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder: one CHUNK-bit slice per stage plus an output register, valid/ready flow.
// Define PIPE_ADDER_OVF_EN to add the registered two's-complement overflow output.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input logic         clk,
    input logic         rst_n,
    pipe_adder_if.slave bus
);

    localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("pipe_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of CHUNK");
    end

    logic             stall;
    logic             out_valid_q;
    logic             cout_q;
    logic [WIDTH-1:0] sum_q;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Stage k keeps the finished low sum bits and only the operand bits not yet consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned RemW = WIDTH - k * CHUNK;
        localparam int unsigned HiW  = RemW - CHUNK;
        localparam int unsigned LoW  = (k + 1) * CHUNK;

        logic [RemW-1:0]  rem_a;
        logic [RemW-1:0]  rem_b;
        logic [CHUNK-1:0] chunk_sum;
        logic             carry_in;
        logic             valid_in;
        logic             chunk_cout;
        logic [LoW-1:0]   sum_lo_d;
        logic [LoW-1:0]   sum_lo_q;
        logic             valid_q;
        logic             carry_q;

        if (k == 0) begin : g_head
            assign rem_a    = bus.a;
            assign rem_b    = bus.b;
            assign carry_in = bus.cin;
            assign valid_in = bus.in_valid;
            assign sum_lo_d = chunk_sum;
        end else begin : g_body
            assign rem_a    = g_stage[k-1].g_fwd.a_hi_q;
            assign rem_b    = g_stage[k-1].g_fwd.b_hi_q;
            assign carry_in = g_stage[k-1].carry_q;
            assign valid_in = g_stage[k-1].valid_q;
            assign sum_lo_d = {chunk_sum, g_stage[k-1].sum_lo_q};
        end

        adder_chunk #(
            .WIDTH(CHUNK)
        ) u_chunk (
            .a    (rem_a[CHUNK-1:0]),
            .b    (rem_b[CHUNK-1:0]),
            .cin  (carry_in),
            .sum  (chunk_sum),
            .cout (chunk_cout)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q  <= 1'b0;
                carry_q  <= 1'b0;
                sum_lo_q <= '0;
            end else if (!stall) begin
                valid_q  <= valid_in;
                carry_q  <= chunk_cout;
                sum_lo_q <= sum_lo_d;
            end
        end

        if (HiW > 0) begin : g_fwd
            logic [HiW-1:0] a_hi_q;
            logic [HiW-1:0] b_hi_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (!stall) begin
                    a_hi_q <= rem_a[RemW-1:CHUNK];
                    b_hi_q <= rem_b[RemW-1:CHUNK];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        // The top chunk still holds the operand sign bits, so overflow is resolved here.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = (rem_a[CHUNK-1] == rem_b[CHUNK-1]) &&
                           (chunk_sum[CHUNK-1] != rem_a[CHUNK-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= g_stage[STAGES-1].valid_q;
            sum_q       <= g_stage[STAGES-1].sum_lo_q;
            cout_q      <= g_stage[STAGES-1].carry_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= g_stage[STAGES-1].g_ovf.ovf_q;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  a, b and cin presented.
REQ-006 SHALL have port in_ready  output  1  operation accepted this cycle when in_valid is also high.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  sum and cout hold a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL fail elaboration unless WIDTH%CHUNK==0 and CHUNK>=1.
REQ-015 SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) in stage k, using the registered carry from stage k-1, or cin for k=0.
REQ-016 SHALL carry unconsumed upper operand chunks and completed lower sum chunks forward in registers alongside each stage valid bit.
REQ-017 SHALL give STAGES cycles latency: an operation accepted at edge N shows out_valid at edge N+STAGES if no stall occurs.
REQ-018 SHALL sustain one accepted operation per cycle while out_ready is high.
REQ-019 SHALL define stall = out_valid & ~out_ready; in_ready SHALL equal ~stall.
REQ-020 SHALL freeze every stage register, including valid bits, while stall is high; sum and cout SHALL then stay stable.
REQ-021 SHALL load stage 0 with valid=in_valid when not stalled, so pipeline bubbles propagate as invalid stages.
REQ-022 SHALL keep results in acceptance order; none is dropped or duplicated.
REQ-023 SHALL make in_ready independent of in_valid and out_valid independent of out_ready within a cycle.

Reset
REQ-024 SHALL clear all stage valid bits, out_valid, sum and cout to 0 immediately on rst_n low.
REQ-025 SHALL discard in-flight operations on reset mid-operation; the first result after release comes from a post-reset acceptance.
REQ-026 SHALL hold in_ready high during and after reset, because stall is 0.

Configuration
REQ-027 With PIPE_ADDER_OVF_EN defined, SHALL add output ovf, 1 bit, the two's-complement overflow (a[MSB]==b[MSB] and sum[MSB]!=a[MSB]), registered and aligned with sum; ovf SHALL reset to 0.
REQ-028 Without PIPE_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL take defaults for WIDTH and CHUNK, and the STAGES derivation, from the shared package adder_pkg.
REQ-030 SHALL instantiate sub-module adder_chunk, a combinational CHUNK-bit ripple adder with inputs a, b, cin and outputs sum, cout, once per stage.

Verification (WIDTH=16, CHUNK=4)
REQ-031 SHALL check a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum=0x5555, cout=0 with out_valid exactly 4 cycles after acceptance.
REQ-032 SHALL check a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, proving the carry crosses all stages.
REQ-033 SHALL check 8 back-to-back operations with out_ready=1 -> 8 correct results on 8 consecutive cycles, in order.
REQ-034 SHALL check a full pipeline with out_ready=0 for 3 cycles -> in_ready=0, sum, cout and out_valid stable, then all results delivered with no loss on release.
REQ-035 SHALL check rst_n pulsed low with 3 operations in flight -> out_valid=0 at once, and no stale result after release.
REQ-036 SHALL check, with PIPE_ADDER_OVF_EN defined, a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1; a=0x0001, b=0x0001 -> ovf=0.
